// File: rtl/rx_buffer.sv
// rx_buffer: 4-phase UART receive handshake feeding a show-ahead byte FIFO.
// Ports: clk, Reset (sync, active-high); receiver side Receive/Dout/parityErr
//        in, Received out; consumer side pop/clr_ovf in, rd_data/rd_perr,
//        empty/full/count, sticky overflow and saturating err_count out.
module rx_buffer #(
    parameter int DEPTH     = 8,
    parameter bit DROP_PERR = 1'b0,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          Receive,
    input  logic [7:0]    Dout,
    input  logic          parityErr,
    output logic          Received,
    input  logic          pop,
    input  logic          clr_ovf,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [7:0]    err_count
);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   capture;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [8:0]    head;

    logic drop;
    logic pop_ok;
    logic wr_en;
    logic ovf_evt;

    // ARM waits for Receive low so a phase that straddles reset
    // is never captured a second time.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            ARM: begin
                if (!Receive) state_nxt = IDLE;
            end
            IDLE: begin
                if (Receive) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!Receive) state_nxt = IDLE;
            end
            default: state_nxt = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) state <= ARM;
        else       state <= state_nxt;
    end

    // Acknowledge comes straight from the state flop.
    assign Received = (state == ACK);

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign drop    = DROP_PERR && parityErr;
    // A full FIFO still accepts the byte when the head leaves this cycle.
    assign wr_en   = capture && !drop && (!full || pop_ok);
    assign ovf_evt = capture && !drop && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop_ok)      count <= count + CW'(1);
            else if (!wr_en && pop_ok) count <= count - CW'(1);
            // A fresh loss wins over a same-cycle clear.
            if (ovf_evt)      overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
            if (capture && parityErr && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

    // Storage holds no reset; empty masks whatever it contains.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {parityErr, Dout};
    end

    assign head    = mem[rd_ptr];
    assign rd_data = empty ? 8'd0 : head[7:0];
    assign rd_perr = empty ? 1'b0 : head[8];

endmodule

// File: tb/tb_rx_buffer.sv
// tb_rx_buffer: drives two rx_buffer instances (DROP_PERR 0 and 1) with
// directed and random handshakes, comparing against queue-based models.
module tb_rx_buffer;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst, rcv, pe, pop, clr;
    logic [7:0] d;

    logic          received [2];
    logic [7:0]    rd_data  [2];
    logic          rd_perr  [2];
    logic          empty    [2];
    logic          full     [2];
    logic [CW-1:0] count    [2];
    logic          overflow [2];
    logic [7:0]    err_cnt  [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rx_buffer #(.DEPTH(DEPTH), .DROP_PERR(1'b0)) u0 (
        .clk(clk), .Reset(rst), .Receive(rcv), .Dout(d),
        .parityErr(pe), .Received(received[0]), .pop(pop),
        .clr_ovf(clr), .rd_data(rd_data[0]), .rd_perr(rd_perr[0]),
        .empty(empty[0]), .full(full[0]), .count(count[0]),
        .overflow(overflow[0]), .err_count(err_cnt[0])
    );

    rx_buffer #(.DEPTH(DEPTH), .DROP_PERR(1'b1)) u1 (
        .clk(clk), .Reset(rst), .Receive(rcv), .Dout(d),
        .parityErr(pe), .Received(received[1]), .pop(pop),
        .clr_ovf(clr), .rd_data(rd_data[1]), .rd_perr(rd_perr[1]),
        .empty(empty[1]), .full(full[1]), .count(count[1]),
        .overflow(overflow[1]), .err_count(err_cnt[1])
    );

    // Reference model: one queue per instance plus handshake bookkeeping.
    logic [8:0] mq [2][$];
    bit m_ovf [2];
    int m_err;
    bit m_ready;
    bit m_acked;

    task automatic model_edge();
        bit cap;
        bit evt;
        bit pop_ok;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                m_ovf[k] = 0;
            end
            m_err   = 0;
            m_ready = 0;
            m_acked = 0;
            return;
        end
        cap = 0;
        if (!rcv) begin
            m_ready = 1;
            m_acked = 0;
        end else if (m_ready) begin
            cap     = 1;
            m_ready = 0;
            m_acked = 1;
        end
        if (cap && pe && m_err < 255) m_err++;
        for (int k = 0; k < 2; k++) begin
            evt    = 0;
            pop_ok = pop && (mq[k].size() > 0);
            if (pop_ok) void'(mq[k].pop_front());
            if (cap && !(k == 1 && pe)) begin
                if (mq[k].size() < DEPTH) mq[k].push_back({pe, d});
                else evt = 1;
            end
            if (evt) m_ovf[k] = 1;
            else if (clr) m_ovf[k] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [8:0] h;
        chk("received0", 32'(received[0]), 32'(m_acked));
        chk("received1", 32'(received[1]), 32'(m_acked));
        for (int k = 0; k < 2; k++) begin
            n = mq[k].size();
            h = (n > 0) ? mq[k][0] : 9'd0;
            chk($sformatf("count%0d", k), 32'(count[k]), 32'(n));
            chk($sformatf("empty%0d", k), 32'(empty[k]), 32'(n == 0));
            chk($sformatf("full%0d", k), 32'(full[k]), 32'(n == DEPTH));
            chk($sformatf("rd_data%0d", k), 32'(rd_data[k]), 32'(h[7:0]));
            chk($sformatf("rd_perr%0d", k), 32'(rd_perr[k]), 32'(h[8]));
            chk($sformatf("overflow%0d", k), 32'(overflow[k]),
                32'(m_ovf[k]));
            chk($sformatf("err_count%0d", k), 32'(err_cnt[k]), 32'(m_err));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic hs(input logic [7:0] b, input logic p,
                      input int high, input logic pop_cap);
        rcv = 1; d = b; pe = p; pop = pop_cap;
        cycle();
        pop = 0;
        for (int i = 1; i < high; i++) cycle();
        rcv = 0;
        cycle();
    endtask

    task automatic pops(input int n);
        pop = 1;
        for (int i = 0; i < n; i++) cycle();
        pop = 0;
    endtask

    initial begin
        rst = 1; rcv = 0; d = 0; pe = 0; pop = 0; clr = 0;
        cycle();
        cycle();
        rst = 0;
        cycle();

        // Single byte, long Receive phase.
        hs(8'h41, 0, 5, 0);
        chk("single_count", 32'(count[0]), 32'd1);
        chk("single_data", 32'(rd_data[0]), 32'h41);
        pops(2);

        // Fill past capacity.
        for (int i = 0; i < 9; i++) hs(8'(i), 0, 2, 0);
        chk("fill_full", 32'(full[0]), 32'd1);
        chk("fill_ovf", 32'(overflow[0]), 32'd1);
        clr = 1;
        cycle();
        clr = 0;
        chk("clr_ovf", 32'(overflow[0]), 32'd0);

        // Full with pop on the capture edge.
        hs(8'h99, 0, 2, 1);
        chk("full_pop_count", 32'(count[0]), 32'd8);
        pops(10);

        // Wrap around the pointers.
        for (int i = 0; i < 5; i++) hs(8'(8'h20 + i), 0, 1, 0);
        pops(5);
        for (int i = 0; i < 6; i++) hs(8'(8'h10 + i), 0, 1, 0);
        pops(7);

        // Parity handling on both instances.
        hs(8'hAA, 1, 2, 0);
        hs(8'h55, 0, 2, 0);
        chk("perr_drop_data", 32'(rd_data[1]), 32'h55);
        chk("perr_keep_flag", 32'(rd_perr[0]), 32'd1);
        pops(3);

        // Reset in the middle of a handshake, Receive held high.
        rcv = 1; d = 8'h77; pe = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("midrst_count", 32'(count[0]), 32'd0);
        rcv = 0;
        cycle();
        hs(8'h66, 0, 2, 0);
        pops(2);

        // Drive err_count into saturation.
        for (int i = 0; i < 260; i++) hs(8'(i), 1, 1, 1);
        chk("err_sat", 32'(err_cnt[0]), 32'd255);
        rst = 1;
        cycle();
        rst = 0;
        cycle();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (rcv) begin
                if ($urandom_range(0, 2) == 0) rcv = 0;
            end else if ($urandom_range(0, 1) == 0) begin
                rcv = 1;
                d   = 8'($urandom);
                pe  = ($urandom_range(0, 4) == 0);
            end
            pop = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0; rcv = 0; pop = 0; clr = 0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
